conv1d_mac_ctrl: RTL and testbench

CONV1D_MAC_CTRL -- requirements
Module: conv1d_mac_ctrl

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_mac_unit.sv | 45 ++++
 rtl/conv1d_mac_ctrl.sv | 117 +++++++++++
 tb/tb_conv1d_mac_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and counter sizing for the 1-D convolution block.
package conv_pkg;
    localparam int DATA_W = 14;
    localparam int ACC_W  = 28;

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUTPUT
    } state_t;

    // Index width for an n-entry store; never below one bit so n=1 still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_mac_unit.sv
// Two-stage signed multiply-accumulate: product register, then accumulator register.
module conv_mac_unit
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              valid_in,
    input  logic              clear_in,
    output logic [ACC_W-1:0]  f,
    output logic              valid_out
);
    localparam int STAGES = 2;

    logic [ACC_W-1:0]  w_a_ext;
    logic [ACC_W-1:0]  w_b_ext;
    logic [ACC_W-1:0]  r_prod;
    logic [ACC_W-1:0]  r_acc;
    logic              r_clr1;
    logic [STAGES-1:0] r_vld_pipe;

    // Sign-extended operands make the low ACC_W bits of an unsigned multiply the exact signed product.
    assign w_a_ext = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
    assign w_b_ext = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod     <= '0;
            r_acc      <= '0;
            r_clr1     <= 1'b0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-2:0], valid_in};
            r_clr1     <= clear_in & valid_in;
            if (valid_in)
                r_prod <= w_a_ext * w_b_ext;
            if (r_vld_pipe[0])
                r_acc <= r_clr1 ? r_prod : r_acc + r_prod;
        end
    end

    assign f         = r_acc;
    assign valid_out = r_vld_pipe[STAGES-1];
endmodule

// File: rtl/conv1d_mac_ctrl.sv
// Loads a filter and an input vector over a valid/ready stream, then streams out
// each valid-position 1-D convolution result through a shared 2-stage MAC.
module conv1d_mac_ctrl
    import conv_pkg::*;
#(
    parameter int LEN_X = 8,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data_in,
    input  logic              s_valid_in,
    output logic              s_ready_in,
    output logic [ACC_W-1:0]  m_data_out,
    output logic              m_valid_out,
    input  logic              m_ready_out
);
    localparam int WW = cnt_w(LEN_W);
    localparam int XW = cnt_w(LEN_X);

    state_t            r_state;
    state_t            w_nxt;
    logic [WW-1:0]     r_wcnt;
    logic [WW-1:0]     r_k;
    logic [XW-1:0]     r_xcnt;
    logic [XW-1:0]     r_o;
    logic              r_drn;
    logic              r_armed;
    logic [DATA_W-1:0] r_w [LEN_W];
    logic [DATA_W-1:0] r_x [LEN_X];

    logic              w_s_hs;
    logic              w_m_hs;
    logic              w_w_last;
    logic              w_x_last;
    logic              w_k_last;
    logic              w_o_last;
    logic [XW-1:0]     w_xidx;
    logic              w_mac_issue;
    logic [ACC_W-1:0]  w_f;
    logic              w_mac_vld;

    // r_armed holds s_ready_in low through reset and releases it on the first edge afterwards.
    assign s_ready_in  = r_armed & ((r_state == LOAD_W) | (r_state == LOAD_X));
    assign m_valid_out = (r_state == OUTPUT);
    assign m_data_out  = m_valid_out ? w_f : '0;

    assign w_s_hs   = s_valid_in & s_ready_in;
    assign w_m_hs   = m_valid_out & m_ready_out;
    assign w_w_last = (r_wcnt == WW'(LEN_W - 1));
    assign w_x_last = (r_xcnt == XW'(LEN_X - 1));
    assign w_k_last = (r_k == WW'(LEN_W - 1));
    assign w_o_last = (int'(r_o) >= LEN_X - LEN_W);
    assign w_xidx   = XW'(int'(r_o) + int'(r_k));

    assign w_mac_issue = (r_state == COMPUTE);

    conv_mac_unit u_mac (
        .clk       (clk),
        .reset     (reset),
        .a         (r_x[w_xidx]),
        .b         (r_w[r_k]),
        .valid_in  (w_mac_issue),
        .clear_in  (r_k == '0),
        .f         (w_f),
        .valid_out (w_mac_vld)
    );

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            LOAD_W:  if (w_s_hs && w_w_last) w_nxt = LOAD_X;
            LOAD_X:  if (w_s_hs && w_x_last) w_nxt = COMPUTE;
            COMPUTE: if (w_k_last) w_nxt = DRAIN;
            // Second drain cycle: the final term has reached the accumulator.
            DRAIN:   if (r_drn && w_mac_vld) w_nxt = OUTPUT;
            OUTPUT:  if (w_m_hs) w_nxt = w_o_last ? LOAD_W : COMPUTE;
            default: w_nxt = LOAD_W;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD_W;
            r_armed <= 1'b0;
            r_wcnt  <= '0;
            r_xcnt  <= '0;
            r_k     <= '0;
            r_o     <= '0;
            r_drn   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_armed <= 1'b1;
            case (r_state)
                LOAD_W: if (w_s_hs) r_wcnt <= w_w_last ? '0 : r_wcnt + WW'(1);
                LOAD_X: begin
                    if (w_s_hs) r_xcnt <= w_x_last ? '0 : r_xcnt + XW'(1);
                    r_o <= '0;
                    r_k <= '0;
                end
                COMPUTE: begin
                    r_k   <= w_k_last ? '0 : r_k + WW'(1);
                    r_drn <= 1'b0;
                end
                DRAIN:  r_drn <= ~r_drn;
                OUTPUT: if (w_m_hs) r_o <= w_o_last ? '0 : r_o + XW'(1);
                default: ;
            endcase
        end
    end

    // Sample storage carries no reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (w_s_hs && r_state == LOAD_W) r_w[r_wcnt] <= s_data_in;
        if (w_s_hs && r_state == LOAD_X) r_x[r_xcnt] <= s_data_in;
    end
endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// Directed bench for conv1d_mac_ctrl: nominal, wrap, backpressure, load gaps, mid-run reset, throughput.
module tb_conv1d_mac_ctrl;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] s_data_in;
    logic              s_valid_in;
    logic              s_ready_in;
    logic [ACC_W-1:0]  m_data_out;
    logic              m_valid_out;
    logic              m_ready_out;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    conv1d_mac_ctrl #(.LEN_X(8), .LEN_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data_in   (s_data_in),
        .s_valid_in  (s_valid_in),
        .s_ready_in  (s_ready_in),
        .m_data_out  (m_data_out),
        .m_valid_out (m_valid_out),
        .m_ready_out (m_ready_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; idles 'gap' cycles (ready must stay high), then transfers one word.
    task automatic push(input int v, input int gap, input string tag);
        int t;
        for (int g = 0; g < gap; g++) begin
            s_valid_in = 1'b0;
            @(negedge clk); #1;
            chk({tag, " ready in gap"}, s_ready_in, 1);
        end
        s_data_in  = DATA_W'(v);
        s_valid_in = 1'b1;
        #1;
        t = 0;
        while (!s_ready_in && t < 50) begin @(negedge clk); #1; t++; end
        chk({tag, " ready"}, s_ready_in, 1);
        @(negedge clk);
        s_valid_in = 1'b0;
    endtask

    task automatic load(input int w[4], input int x[8], input int gap, input string tag);
        for (int i = 0; i < 4; i++) push(w[i], gap, tag);
        for (int i = 0; i < 8; i++) push(x[i], gap, tag);
        #1;
        chk({tag, " ready low after load"}, s_ready_in, 0);
        chk({tag, " no valid after load"}, m_valid_out, 0);
        chk({tag, " data zero after load"}, m_data_out, 0);
    endtask

    // Waits for a result (m_ready_out held high by caller), checks it, returns its cycle stamp.
    task automatic get_out(input longint exp, input string tag, output int at);
        int t;
        #1;
        t = 0;
        while (!m_valid_out && t < 60) begin @(negedge clk); #1; t++; end
        chk({tag, " valid"}, m_valid_out, 1);
        chk({tag, " data"}, $signed(m_data_out), exp);
        at = cyc;
        @(negedge clk);
    endtask

    task automatic expect_outs(input longint e[5], input string tag, input logic timing);
        int at;
        int prev;
        prev = 0;
        for (int o = 0; o < 5; o++) begin
            get_out(e[o], tag, at);
            if (timing && o > 0) chk({tag, " spacing"}, at - prev, 7);
            prev = at;
        end
        #1;
        chk({tag, " ready after last output"}, s_ready_in, 1);
    endtask

    int     at0;
    int     t;
    int     w_nom[4]  = '{1, 2, 3, 4};
    int     x_nom[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    longint y_nom[5]  = '{30, 40, 50, 60, 70};

    initial begin
        reset       = 1'b1;
        s_data_in   = '0;
        s_valid_in  = 1'b0;
        m_ready_out = 1'b0;
        #1;
        chk("reset s_ready", s_ready_in, 0);
        chk("reset m_valid", m_valid_out, 0);
        chk("reset m_data", m_data_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready before first edge", s_ready_in, 0);
        @(negedge clk); #1;
        chk("ready after first edge", s_ready_in, 1);

        // Nominal run with consumer always ready; also measures output spacing.
        m_ready_out = 1'b1;
        load(w_nom, x_nom, 0, "nominal");
        expect_outs(y_nom, "nominal", 1'b1);

        // 4 * 2^26 wraps to 0 modulo 2^28.
        load('{-8192, -8192, -8192, -8192}, '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192}, 0, "wrap0");
        expect_outs('{0, 0, 0, 0, 0}, "wrap0", 1'b0);

        load('{-8192, 0, 0, 0}, '{8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191}, 0, "wrapneg");
        expect_outs('{-67100672, -67100672, -67100672, -67100672, -67100672}, "wrapneg", 1'b0);

        // Backpressure: first result must hold for 3 stalled cycles, then appear exactly once.
        m_ready_out = 1'b0;
        load(w_nom, x_nom, 0, "bp");
        #1;
        t = 0;
        while (!m_valid_out && t < 60) begin @(negedge clk); #1; t++; end
        for (int i = 0; i < 3; i++) begin
            chk("bp stall valid", m_valid_out, 1);
            chk("bp stall data", $signed(m_data_out), 30);
            @(negedge clk); #1;
        end
        m_ready_out = 1'b1;
        expect_outs(y_nom, "bp", 1'b0);

        // Load with an idle cycle before every word.
        load(w_nom, x_nom, 1, "gaps");
        expect_outs(y_nom, "gaps", 1'b0);

        // Reset during COMPUTE of o=2, then a fresh load must behave normally.
        load(w_nom, x_nom, 0, "rst");
        get_out(30, "rst o0", at0);
        get_out(40, "rst o1", at0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst m_valid", m_valid_out, 0);
        chk("midrst m_data", m_data_out, 0);
        chk("midrst s_ready", s_ready_in, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst ready before edge", s_ready_in, 0);
        @(negedge clk); #1;
        chk("midrst ready after edge", s_ready_in, 1);
        load(w_nom, x_nom, 0, "postrst");
        expect_outs(y_nom, "postrst", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
